// File: rtl/rv32i_types_pkg.sv
// rtl/rv32i_types_pkg.sv - shared vector memory types: element width, offsets, sequencer state
package rv32i_types_pkg;

  typedef enum logic [1:0] {
    SEW8  = 2'd0,
    SEW16 = 2'd1,
    SEW32 = 2'd2
  } sew_t;

  typedef logic [2:0] offset_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ0 = 2'd1,
    REQ1 = 2'd2,
    WB   = 2'd3
  } vmem_state_t;

  typedef struct packed {
    logic        load;
    logic        store;
    logic [1:0]  wen;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] sdata0;
    logic [31:0] sdata1;
    offset_t     woff0;
    offset_t     woff1;
    sew_t        eew;
    logic [4:0]  vd;
  } vmem_req_t;

  // Natural alignment: halves on even bytes, words on word boundaries.
  function automatic logic lane_misaligned(input sew_t sew, input logic [1:0] lo);
    case (sew)
      SEW16:   return lo[0];
      SEW32:   return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv32v_mem_lane_align.sv
// rtl/rv32v_mem_lane_align.sv - byte-lane steering for one vector element access
module rv32v_mem_lane_align
  import rv32i_types_pkg::*;
#(
  parameter bit SIGN_EXT = 1'b0
) (
  input  sew_t        sew,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_elem,
  input  logic [31:0] rdata,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata,
  output logic [31:0] load_elem,
  output logic        misaligned
);

  logic [4:0]  shamt;
  logic [31:0] shifted;

  always_comb begin
    byte_en   = 4'b0000;
    wdata     = '0;
    shamt     = '0;
    shifted   = '0;
    load_elem = '0;
    case (sew)
      SEW16: begin
        byte_en = 4'b0011 << {addr_lo[1], 1'b0};
        wdata   = {2{store_elem[15:0]}};
        shamt   = {addr_lo[1], 4'b0000};
      end
      SEW32: begin
        byte_en = 4'b1111;
        wdata   = store_elem;
      end
      default: begin
        byte_en = 4'b0001 << addr_lo;
        wdata   = {4{store_elem[7:0]}};
        shamt   = {addr_lo, 3'b000};
      end
    endcase
    shifted = rdata >> shamt;
    case (sew)
      SEW16:   load_elem = {{16{SIGN_EXT & shifted[15]}}, shifted[15:0]};
      SEW32:   load_elem = shifted;
      default: load_elem = {{24{SIGN_EXT & shifted[7]}}, shifted[7:0]};
    endcase
  end

  assign misaligned = lane_misaligned(sew, addr_lo);

endmodule

// File: rtl/rv32v_memory_sequencer.sv
// rtl/rv32v_memory_sequencer.sv - two-lane vector load/store sequencer onto a single data bus
module rv32v_memory_sequencer
  import rv32i_types_pkg::*;
#(
  parameter bit SIGN_EXT = 1'b0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ex_valid,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [1:0]  ex_wen,
  input  logic [31:0] ex_aluresult0,
  input  logic [31:0] ex_aluresult1,
  input  logic [31:0] ex_storedata0,
  input  logic [31:0] ex_storedata1,
  input  offset_t     ex_woffset0,
  input  offset_t     ex_woffset1,
  input  sew_t        ex_eew,
  input  logic [4:0]  ex_vd,
  output logic        ex_stall,
  output logic [31:0] dmem_addr,
  output logic        dmem_ren,
  output logic        dmem_wen,
  output logic [3:0]  dmem_byte_en,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_busy,
  output logic        wb_valid,
  output logic [1:0]  wb_wen,
  output logic [31:0] wb_wdat0,
  output logic [31:0] wb_wdat1,
  output offset_t     wb_woffset0,
  output offset_t     wb_woffset1,
  output logic [4:0]  wb_vd,
  output logic [1:0]  wb_misaligned
);

  vmem_state_t state_q, state_d;
  vmem_req_t   req_q, req_d;
  logic [31:0] wdat0_q, wdat0_d, wdat1_q, wdat1_d;
  logic [1:0]  mis_q, mis_d;

  logic        capture, cap_mem, in_req, lane_sel, lane_mis;
  logic [1:0]  cap_mis, cap_act;
  logic [31:0] lane_addr, lane_sdata, lane_wdata, lane_load;
  logic [3:0]  lane_be;

  assign capture  = ex_valid && !ex_stall;
  assign in_req   = (state_q == REQ0) || (state_q == REQ1);
  assign lane_sel = (state_q == REQ1);

  // Misaligned lanes are dropped at capture so they never cost a bus cycle.
  always_comb begin
    cap_mem = ex_load | ex_store;
    cap_mis = 2'b00;
    if (cap_mem) begin
      cap_mis = ex_wen & {lane_misaligned(ex_eew, ex_aluresult1[1:0]),
                          lane_misaligned(ex_eew, ex_aluresult0[1:0])};
    end
    cap_act = cap_mem ? (ex_wen & ~cap_mis) : 2'b00;
  end

  always_comb begin
    lane_addr  = lane_sel ? req_q.addr1  : req_q.addr0;
    lane_sdata = lane_sel ? req_q.sdata1 : req_q.sdata0;
  end

  rv32v_mem_lane_align #(
    .SIGN_EXT(SIGN_EXT)
  ) u_align (
    .sew       (req_q.eew),
    .addr_lo   (lane_addr[1:0]),
    .store_elem(lane_sdata),
    .rdata     (dmem_rdata),
    .byte_en   (lane_be),
    .wdata     (lane_wdata),
    .load_elem (lane_load),
    .misaligned(lane_mis)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      REQ0:    if (!dmem_busy) state_d = (req_q.wen[1] && !mis_q[1]) ? REQ1 : WB;
      REQ1:    if (!dmem_busy) state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (capture) begin
      state_d = cap_act[0] ? REQ0 : (cap_act[1] ? REQ1 : WB);
    end
  end

  always_comb begin
    req_d   = req_q;
    mis_d   = mis_q;
    wdat0_d = wdat0_q;
    wdat1_d = wdat1_q;
    if (capture) begin
      req_d.load   = ex_load;
      req_d.store  = ex_store;
      req_d.wen    = ex_wen;
      req_d.addr0  = ex_aluresult0;
      req_d.addr1  = ex_aluresult1;
      req_d.sdata0 = ex_storedata0;
      req_d.sdata1 = ex_storedata1;
      req_d.woff0  = ex_woffset0;
      req_d.woff1  = ex_woffset1;
      req_d.eew    = ex_eew;
      req_d.vd     = ex_vd;
      mis_d        = cap_mis;
      wdat0_d      = (!cap_mem && ex_wen[0]) ? ex_aluresult0 : '0;
      wdat1_d      = (!cap_mem && ex_wen[1]) ? ex_aluresult1 : '0;
    end else if (in_req && !dmem_busy && req_q.load) begin
      if (lane_sel) wdat1_d = lane_load;
      else          wdat0_d = lane_load;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      req_q   <= '0;
      mis_q   <= '0;
      wdat0_q <= '0;
      wdat1_q <= '0;
    end else begin
      req_q   <= req_d;
      mis_q   <= mis_d;
      wdat0_q <= wdat0_d;
      wdat1_q <= wdat1_d;
    end
  end

  // A load wins over a store when both are flagged.
  always_comb begin
    ex_stall      = 1'b0;
    dmem_addr     = '0;
    dmem_ren      = 1'b0;
    dmem_wen      = 1'b0;
    dmem_byte_en  = 4'b0000;
    dmem_wdata    = '0;
    wb_valid      = 1'b0;
    wb_wen        = 2'b00;
    wb_wdat0      = '0;
    wb_wdat1      = '0;
    wb_woffset0   = '0;
    wb_woffset1   = '0;
    wb_vd         = '0;
    wb_misaligned = 2'b00;
    case (state_q)
      REQ0, REQ1: begin
        ex_stall = 1'b1;
        if (!lane_mis) begin
          dmem_addr    = {lane_addr[31:2], 2'b00};
          dmem_ren     = req_q.load;
          dmem_wen     = req_q.store & ~req_q.load;
          dmem_byte_en = lane_be;
          dmem_wdata   = lane_wdata;
        end
      end
      WB: begin
        wb_valid      = 1'b1;
        wb_wen        = req_q.wen & ~mis_q;
        wb_wdat0      = wdat0_q;
        wb_wdat1      = wdat1_q;
        wb_woffset0   = req_q.woff0;
        wb_woffset1   = req_q.woff1;
        wb_vd         = req_q.vd;
        wb_misaligned = mis_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rv32v_memory_sequencer.sv
// tb/tb_rv32v_memory_sequencer.sv - self-checking bench for rv32v_memory_sequencer
module tb_rv32v_memory_sequencer;
  import rv32i_types_pkg::*;

  logic        CLK, nRST;
  logic        ex_valid, ex_load, ex_store;
  logic [1:0]  ex_wen;
  logic [31:0] ex_aluresult0, ex_aluresult1, ex_storedata0, ex_storedata1;
  offset_t     ex_woffset0, ex_woffset1;
  sew_t        ex_eew;
  logic [4:0]  ex_vd;
  logic [31:0] dmem_rdata;
  logic        dmem_busy;

  logic        ex_stall, dmem_ren, dmem_wen, wb_valid;
  logic [31:0] dmem_addr, dmem_wdata, wb_wdat0, wb_wdat1;
  logic [3:0]  dmem_byte_en;
  logic [1:0]  wb_wen, wb_misaligned;
  offset_t     wb_woffset0, wb_woffset1;
  logic [4:0]  wb_vd;

  logic        s_ex_stall, s_dmem_ren, s_dmem_wen, s_wb_valid;
  logic [31:0] s_dmem_addr, s_dmem_wdata, s_wb_wdat0, s_wb_wdat1;
  logic [3:0]  s_dmem_byte_en;
  logic [1:0]  s_wb_wen, s_wb_misaligned;
  offset_t     s_wb_woffset0, s_wb_woffset1;
  logic [4:0]  s_wb_vd;

  rv32v_memory_sequencer #(.SIGN_EXT(1'b0)) dut (
    .CLK(CLK), .nRST(nRST), .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
    .ex_wen(ex_wen), .ex_aluresult0(ex_aluresult0), .ex_aluresult1(ex_aluresult1),
    .ex_storedata0(ex_storedata0), .ex_storedata1(ex_storedata1),
    .ex_woffset0(ex_woffset0), .ex_woffset1(ex_woffset1), .ex_eew(ex_eew), .ex_vd(ex_vd),
    .ex_stall(ex_stall), .dmem_addr(dmem_addr), .dmem_ren(dmem_ren), .dmem_wen(dmem_wen),
    .dmem_byte_en(dmem_byte_en), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_busy(dmem_busy), .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_wdat0(wb_wdat0),
    .wb_wdat1(wb_wdat1), .wb_woffset0(wb_woffset0), .wb_woffset1(wb_woffset1),
    .wb_vd(wb_vd), .wb_misaligned(wb_misaligned)
  );

  rv32v_memory_sequencer #(.SIGN_EXT(1'b1)) dut_sx (
    .CLK(CLK), .nRST(nRST), .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
    .ex_wen(ex_wen), .ex_aluresult0(ex_aluresult0), .ex_aluresult1(ex_aluresult1),
    .ex_storedata0(ex_storedata0), .ex_storedata1(ex_storedata1),
    .ex_woffset0(ex_woffset0), .ex_woffset1(ex_woffset1), .ex_eew(ex_eew), .ex_vd(ex_vd),
    .ex_stall(s_ex_stall), .dmem_addr(s_dmem_addr), .dmem_ren(s_dmem_ren), .dmem_wen(s_dmem_wen),
    .dmem_byte_en(s_dmem_byte_en), .dmem_wdata(s_dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_busy(dmem_busy), .wb_valid(s_wb_valid), .wb_wen(s_wb_wen), .wb_wdat0(s_wb_wdat0),
    .wb_wdat1(s_wb_wdat1), .wb_woffset0(s_wb_woffset0), .wb_woffset1(s_wb_woffset1),
    .wb_vd(s_wb_vd), .wb_misaligned(s_wb_misaligned)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    bit        ld, st;
    bit [1:0]  wen, eew;
    bit [31:0] a0, a1, d0, d1, r0, r1;
    bit [7:0]  b0, b1;
    bit [2:0]  o0, o1;
    bit [4:0]  vd;
    bit [31:0] w0, w1, sw0, sw1;
    bit [1:0]  ewen, emis;
    bit [7:0]  ebe;
    bit [31:0] ewd0;
    bit [7:0]  elat;
  } vec_t;

  typedef struct packed {
    bit        lane, rd;
    bit [7:0]  busy;
    bit [31:0] addr;
    bit [3:0]  be;
    bit [31:0] wdata, rdata;
  } breq_t;

  int n_chk = 0;
  int n_err = 0;
  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  function automatic int size_of(input bit [1:0] e);
    return (e == 2'd0) ? 1 : ((e == 2'd1) ? 2 : 4);
  endfunction

  function automatic bit [31:0] ext(input bit [31:0] r, input bit [31:0] a, input int n, input bit se);
    bit [31:0] mask, v;
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    v = (r >> (8 * (a % 4))) & mask;
    if (se && n < 4 && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // Reference: what one lane should produce, from element size and address arithmetic.
  task automatic lane_model(input vec_t v, input int k, output bit req, output breq_t r,
                            output bit [31:0] w, output bit [31:0] sw, output bit m);
    bit [31:0] a, d, rd, mask;
    int n;
    a = (k == 1) ? v.a1 : v.a0;
    d = (k == 1) ? v.d1 : v.d0;
    rd = (k == 1) ? v.r1 : v.r0;
    n = size_of(v.eew);
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    req = 1'b0; r = '0; w = '0; sw = '0; m = 1'b0;
    if (!v.wen[k]) return;
    if (!(v.ld || v.st)) begin
      w = a; sw = a;
      return;
    end
    if ((a % n) != 0) begin
      m = 1'b1;
      return;
    end
    req = 1'b1;
    r.lane = (k == 1);
    r.rd = v.ld;
    r.busy = (k == 1) ? v.b1 : v.b0;
    r.addr = a & ~32'h3;
    r.be = 4'(((1 << n) - 1) << (a % 4));
    r.rdata = rd;
    for (int i = 0; i < 4 / n; i++) r.wdata = r.wdata | ((d & mask) << (8 * n * i));
    if (v.ld) begin
      w = ext(rd, a, n, 1'b0);
      sw = ext(rd, a, n, 1'b1);
    end
  endtask

  task automatic run_txn(input vec_t v, input bit use_tab);
    breq_t q[$];
    breq_t r0, r1;
    bit req0, req1, m0, m1;
    bit [31:0] mw0, mw1, ms0, ms1, seen_wd0;
    bit [7:0] seen_be;
    int mlat, cyc, bl, guard;
    bit got;
    lane_model(v, 0, req0, r0, mw0, ms0, m0);
    lane_model(v, 1, req1, r1, mw1, ms1, m1);
    mlat = 0;
    if (req0) begin q.push_back(r0); mlat += int'(r0.busy) + 1; end
    if (req1) begin q.push_back(r1); mlat += int'(r1.busy) + 1; end
    guard = 0;
    while (ex_stall && guard < 50) begin step; guard++; end
    ex_load = v.ld; ex_store = v.st; ex_wen = v.wen; ex_eew = sew_t'(v.eew);
    ex_aluresult0 = v.a0; ex_aluresult1 = v.a1; ex_storedata0 = v.d0; ex_storedata1 = v.d1;
    ex_woffset0 = v.o0; ex_woffset1 = v.o1; ex_vd = v.vd; ex_valid = 1'b1;
    step;
    ex_valid = 1'b0;
    cyc = 0; bl = -1; got = 1'b0; seen_be = '0; seen_wd0 = '0;
    while (!got && cyc < 64) begin
      if (dmem_ren || dmem_wen) begin
        if (q.size() == 0) begin
          chk("spurious_req", {30'd0, dmem_ren, dmem_wen}, 32'd0);
        end else begin
          chk("req_addr", dmem_addr, q[0].addr);
          chk("req_ren", dmem_ren, q[0].rd);
          chk("req_wen", dmem_wen, !q[0].rd);
          chk("req_be", dmem_byte_en, q[0].be);
          if (!q[0].rd) chk("req_wdata", dmem_wdata, q[0].wdata);
          chk("req_stall", ex_stall, 1);
          if (q[0].lane) seen_be[7:4] = dmem_byte_en;
          else begin seen_be[3:0] = dmem_byte_en; seen_wd0 = dmem_wdata; end
          if (bl < 0) bl = int'(q[0].busy);
          if (bl > 0) begin
            dmem_busy = 1'b1; dmem_rdata = $urandom; bl--;
          end else begin
            dmem_busy = 1'b0; dmem_rdata = q[0].rdata; void'(q.pop_front()); bl = -1;
          end
        end
      end else begin
        dmem_busy = 1'b0; dmem_rdata = $urandom;
      end
      if (wb_valid) got = 1'b1;
      else begin step; cyc++; end
    end
    chk("wb_timeout", wb_valid, 1);
    if (got) begin
      chk("wb_latency", cyc, mlat);
      chk("reqs_left", q.size(), 0);
      chk("wb_wen", wb_wen, v.wen & ~{m1, m0});
      chk("wb_mis", wb_misaligned, {m1, m0});
      chk("wb_wdat0", wb_wdat0, mw0);
      chk("wb_wdat1", wb_wdat1, mw1);
      chk("wb_sx_wdat0", s_wb_wdat0, ms0);
      chk("wb_sx_wdat1", s_wb_wdat1, ms1);
      chk("wb_vd", wb_vd, v.vd);
      chk("wb_off", {wb_woffset1, wb_woffset0}, {v.o1, v.o0});
      if (use_tab) begin
        chk("tab_wdat0", wb_wdat0, v.w0);
        chk("tab_wdat1", wb_wdat1, v.w1);
        chk("tab_sx_wdat0", s_wb_wdat0, v.sw0);
        chk("tab_sx_wdat1", s_wb_wdat1, v.sw1);
        chk("tab_wen", wb_wen, v.ewen);
        chk("tab_mis", wb_misaligned, v.emis);
        chk("tab_be", seen_be, v.ebe);
        chk("tab_latency", cyc, v.elat);
        if (v.st && !v.ld && v.ebe[3:0] != 0) chk("tab_wdata0", seen_wd0, v.ewd0);
      end
    end
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_ren"}, dmem_ren, 0);
    chk({nm, "_wen"}, dmem_wen, 0);
    chk({nm, "_addr"}, dmem_addr, 0);
    chk({nm, "_be"}, dmem_byte_en, 0);
    chk({nm, "_stall"}, ex_stall, 0);
    chk({nm, "_wbv"}, wb_valid, 0);
  endtask

  initial begin
    vec_t rv;
    int kind;
    vecs[0]  = '{default: 0, wen: 2'b11, a0: 32'h11, a1: 32'h22, o0: 3'd1, o1: 3'd2, vd: 5'd3,
                 w0: 32'h11, w1: 32'h22, sw0: 32'h11, sw1: 32'h22, ewen: 2'b11};
    vecs[1]  = '{default: 0, ld: 1, wen: 2'b11, eew: 2'd0, a0: 32'h1003, a1: 32'h2001,
                 r0: 32'hAABBCCDD, r1: 32'hAABBCCDD, w0: 32'hAA, w1: 32'hCC,
                 sw0: 32'hFFFFFFAA, sw1: 32'hFFFFFFCC, ewen: 2'b11, ebe: 8'h28, elat: 8'd2};
    vecs[2]  = '{default: 0, st: 1, wen: 2'b01, eew: 2'd1, a0: 32'h102, d0: 32'h1234, b0: 8'd3,
                 ewen: 2'b01, ebe: 8'h0C, ewd0: 32'h12341234, elat: 8'd4};
    vecs[3]  = '{default: 0, ld: 1, wen: 2'b11, eew: 2'd2, a0: 32'h101, a1: 32'h200,
                 r1: 32'hDEADBEEF, w1: 32'hDEADBEEF, sw1: 32'hDEADBEEF, ewen: 2'b10,
                 emis: 2'b01, ebe: 8'hF0, elat: 8'd1};
    vecs[4]  = '{default: 0, ld: 1, wen: 2'b10, eew: 2'd1, a0: 32'h55, a1: 32'h306,
                 r1: 32'h80017FFF, w1: 32'h8001, sw1: 32'hFFFF8001, ewen: 2'b10,
                 ebe: 8'hC0, elat: 8'd1};
    vecs[5]  = '{default: 0, wen: 2'b01, a0: 32'hCAFE0001, a1: 32'h12345678, vd: 5'd31,
                 w0: 32'hCAFE0001, sw0: 32'hCAFE0001, ewen: 2'b01};
    vecs[6]  = '{default: 0, st: 1, wen: 2'b11, eew: 2'd0, a0: 32'h7, a1: 32'h4, d0: 32'h1AB,
                 d1: 32'h3C, b0: 8'd1, ewen: 2'b11, ebe: 8'h18, ewd0: 32'hABABABAB, elat: 8'd3};
    vecs[7]  = '{default: 0, ld: 1, st: 1, wen: 2'b01, eew: 2'd0, a0: 32'h0, r0: 32'h12345680,
                 w0: 32'h80, sw0: 32'hFFFFFF80, ewen: 2'b01, ebe: 8'h01, elat: 8'd1};
    vecs[8]  = '{default: 0, ld: 1, wen: 2'b00, eew: 2'd2, a0: 32'h100};
    vecs[9]  = '{default: 0, ld: 1, wen: 2'b11, eew: 2'd1, a0: 32'h1, a1: 32'h3, emis: 2'b11};
    vecs[10] = '{default: 0, st: 1, wen: 2'b10, eew: 2'd2, a1: 32'h40C, d1: 32'h89ABCDEF,
                 b1: 8'd2, ewen: 2'b10, ebe: 8'hF0, elat: 8'd3};

    nRST = 1'b0; ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_wen = 2'b00;
    ex_aluresult0 = '0; ex_aluresult1 = '0; ex_storedata0 = '0; ex_storedata1 = '0;
    ex_woffset0 = '0; ex_woffset1 = '0; ex_eew = SEW8; ex_vd = '0;
    dmem_rdata = '0; dmem_busy = 1'b0;
    step; step;
    chk_quiet("reset");
    chk("reset_wbwen", wb_wen, 0);
    chk("reset_wdat", wb_wdat0 | wb_wdat1, 0);
    chk("reset_mis", wb_misaligned, 0);
    @(negedge CLK);
    nRST = 1'b1;
    step;

    for (int i = 0; i < 11; i++) run_txn(vecs[i], 1'b1);

    // Reset while lane 1 is outstanding, then a late response.
    step; step;
    ex_load = 1'b1; ex_store = 1'b0; ex_wen = 2'b11; ex_eew = SEW32;
    ex_aluresult0 = 32'h100; ex_aluresult1 = 32'h204; ex_valid = 1'b1; dmem_busy = 1'b0;
    step;
    ex_valid = 1'b0;
    chk("rst_req0_addr", dmem_addr, 32'h100);
    step;
    chk("rst_req1_addr", dmem_addr, 32'h204);
    dmem_busy = 1'b1;
    step;
    chk("rst_req1_held", dmem_ren, 1);
    #2 nRST = 1'b0;
    #1 chk_quiet("rst_async");
    @(negedge CLK);
    nRST = 1'b1;
    dmem_busy = 1'b0; dmem_rdata = 32'h5A5A5A5A;
    for (int i = 0; i < 3; i++) begin
      step;
      chk_quiet("rst_after");
    end

    for (int i = 0; i < 80; i++) begin
      rv = '0;
      kind = $urandom_range(0, 2);
      rv.ld = (kind == 1) || ($urandom_range(0, 7) == 0 && kind == 2);
      rv.st = (kind == 2);
      rv.wen = 2'($urandom_range(0, 3));
      rv.eew = 2'($urandom_range(0, 2));
      rv.a0 = $urandom; rv.a1 = $urandom; rv.d0 = $urandom; rv.d1 = $urandom;
      rv.r0 = $urandom; rv.r1 = $urandom;
      rv.b0 = 8'($urandom_range(0, 3)); rv.b1 = 8'($urandom_range(0, 3));
      rv.o0 = 3'($urandom); rv.o1 = 3'($urandom); rv.vd = 5'($urandom);
      run_txn(rv, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
